// File: rtl/keccak_miner_pkg.sv
// Shared widths and sweep-state encoding for the keccak nonce sweeper slice.
package keccak_miner_pkg;
  localparam int unsigned HDR_W    = 608;
  localparam int unsigned NONCE_W  = 32;
  localparam int unsigned TARGET_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } sweep_state_e;
endpackage

// File: rtl/keccak_nonce_sweeper_if.sv
// Host-side bundle: work offer handshake in, golden-nonce handshake out.
// master = host/UART side, slave = sweeper.
interface keccak_nonce_sweeper_if;
  import keccak_miner_pkg::*;

  logic                work_valid;
  logic                work_ready;
  logic [HDR_W-1:0]    work_header;
  logic [TARGET_W-1:0] work_target;
  logic [NONCE_W-1:0]  work_nstart;
  logic [NONCE_W-1:0]  work_nend;
  logic                gn_valid;
  logic                gn_ready;
  logic [NONCE_W-1:0]  gn_nonce;

  modport master (
    output work_valid, work_header, work_target, work_nstart, work_nend, gn_ready,
    input  work_ready, gn_valid, gn_nonce
  );

  modport slave (
    input  work_valid, work_header, work_target, work_nstart, work_nend, gn_ready,
    output work_ready, gn_valid, gn_nonce
  );
endinterface

// File: rtl/keccak_nonce_sweeper_fifo.sv
// gn_fifo: synchronous first-word-fall-through FIFO for golden nonces.
// A push while full is accepted only if a pop happens in the same cycle.
module gn_fifo
  import keccak_miner_pkg::*;
#(
  parameter int unsigned WIDTH = NONCE_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/keccak_nonce_sweeper.sv
// keccak_nonce_sweeper: drives the free-running keccak core with one nonce per
// clock over an inclusive (mod 2^32) range and realigns gn_match to its nonce.
// Optional feature: define KECCAK_HASH_CNT_EN to add a saturating hash_cnt output.
module keccak_nonce_sweeper
  import keccak_miner_pkg::*;
#(
  parameter int unsigned CORE_LATENCY = 67,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  keccak_nonce_sweeper_if.slave bus,
  input  logic                abort,
  output logic [HDR_W-1:0]    core_header,
  output logic [NONCE_W-1:0]  core_nonce,
  output logic [TARGET_W-1:0] core_target,
  input  logic                core_match,
  output logic                busy,
  output logic                done,
  output logic                overflow
`ifdef KECCAK_HASH_CNT_EN
  ,
  output logic [47:0]         hash_cnt
`endif
);
  localparam int unsigned DC_W = $clog2(CORE_LATENCY + 1);

  sweep_state_e       state;
  sweep_state_e       state_next;
  logic [NONCE_W-1:0] job_nend;
  logic [DC_W-1:0]    drain_cnt;
  logic               accept;
  logic               flush;
  logic               sweeping;
  logic               last_nonce;

  logic [CORE_LATENCY-1:0] dl_live;
  logic [NONCE_W-1:0]      dl_nonce [CORE_LATENCY];

  logic fifo_push;
  logic fifo_pop;
  logic fifo_full;
  logic fifo_empty;

  assign bus.work_ready = (state == ST_IDLE) || (state == ST_DONE);
  assign busy           = (state == ST_SWEEP) || (state == ST_DRAIN);
  assign done           = (state == ST_DONE);
  assign sweeping       = (state == ST_SWEEP);
  assign last_nonce     = (core_nonce == job_nend);

  // Next-state decode; flush kills every in-flight live tag on abort or new work.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    flush      = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.work_valid) begin
          state_next = ST_SWEEP;
          accept     = 1'b1;
          flush      = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (abort) begin
          state_next = ST_IDLE;
          flush      = 1'b1;
        end else if (last_nonce) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_next = ST_IDLE;
          flush      = 1'b1;
        end else if (drain_cnt == DC_W'(CORE_LATENCY - 1)) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Job latch and nonce counter; the counter only advances while the sweep continues.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_header <= '0;
      core_target <= '0;
      core_nonce  <= '0;
      job_nend    <= '0;
    end else if (accept) begin
      core_header <= bus.work_header;
      core_target <= bus.work_target;
      core_nonce  <= bus.work_nstart;
      job_nend    <= bus.work_nend;
    end else if (sweeping && (state_next == ST_SWEEP)) begin
      core_nonce  <= core_nonce + NONCE_W'(1);
    end
  end

  // Drain timer: counts cycles spent in DRAIN.
  always_ff @(posedge clk) begin
    if (!rst_n || (state != ST_DRAIN)) drain_cnt <= '0;
    else                               drain_cnt <= drain_cnt + DC_W'(1);
  end

  // Live tags of the delay line; entry CORE_LATENCY-1 lines up with core_match.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      dl_live <= '0;
    end else begin
      dl_live[0] <= sweeping;
      for (int unsigned i = 1; i < CORE_LATENCY; i++) dl_live[i] <= dl_live[i-1];
    end
  end

  // Nonce payload of the delay line; validity is carried entirely by dl_live.
  always_ff @(posedge clk) begin
    dl_nonce[0] <= core_nonce;
    for (int unsigned i = 1; i < CORE_LATENCY; i++) dl_nonce[i] <= dl_nonce[i-1];
  end

  assign fifo_push    = core_match && dl_live[CORE_LATENCY-1];
  assign fifo_pop     = bus.gn_valid && bus.gn_ready;
  assign bus.gn_valid = !fifo_empty;

  gn_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_gn_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (dl_nonce[CORE_LATENCY-1]),
    .pop   (fifo_pop),
    .dout  (bus.gn_nonce),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow; a drop in the same cycle as new work still sets it.
  always_ff @(posedge clk) begin
    if (!rst_n)                                  overflow <= 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
    else if (accept)                              overflow <= 1'b0;
  end

`ifdef KECCAK_HASH_CNT_EN
  // Saturating count of live nonces issued to the core.
  always_ff @(posedge clk) begin
    if (!rst_n)                         hash_cnt <= '0;
    else if (sweeping && hash_cnt != '1) hash_cnt <= hash_cnt + 48'd1;
  end
`endif
endmodule

// File: tb/tb_keccak_nonce_sweeper.sv
// Self-checking bench for keccak_nonce_sweeper with a behavioural core model:
// core_match = (nonce == golden || match_all) delayed L clocks.
// Build with KECCAK_HASH_CNT_EN defined to also check hash_cnt.
module tb_keccak_nonce_sweeper;
  import keccak_miner_pkg::*;

  localparam int unsigned L = 67;

  logic clk = 1'b0;
  logic rst_n;
  logic abort;
  logic [HDR_W-1:0]    core_header;
  logic [NONCE_W-1:0]  core_nonce;
  logic [TARGET_W-1:0] core_target;
  logic core_match;
  logic busy, done, overflow;
`ifdef KECCAK_HASH_CNT_EN
  logic [47:0] hash_cnt;
`endif

  keccak_nonce_sweeper_if bus ();

  keccak_nonce_sweeper #(
    .CORE_LATENCY (L),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .abort       (abort),
    .core_header (core_header),
    .core_nonce  (core_nonce),
    .core_target (core_target),
    .core_match  (core_match),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
`ifdef KECCAK_HASH_CNT_EN
    ,
    .hash_cnt    (hash_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural core model
  logic [L-1:0] pipe = '0;
  logic [31:0]  golden = 32'hFFFF_FFFF;
  logic         match_all = 1'b0;
  always @(posedge clk) pipe <= {pipe[L-2:0], match_all || (core_nonce == golden)};
  assign core_match = pipe[L-1];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard pop on every golden-nonce handshake
  always @(negedge clk) begin
    if (rst_n && bus.gn_valid && bus.gn_ready) begin
      check_eq("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        check_eq("gn_nonce", 64'(bus.gn_nonce), 64'(sb[0]));
        void'(sb.pop_front());
      end
    end
  end

  task automatic start_job(input logic [HDR_W-1:0] h, input logic [31:0] t,
                           input logic [31:0] ns, input logic [31:0] ne,
                           input bit expect_hits, input int keep);
    logic [31:0] span;
    logic [31:0] n;
    int pushed;
    int waited;
    span = ne - ns;
    pushed = 0;
    waited = 0;
    while (!bus.work_ready && waited < 2000) begin
      tick(1);
      waited++;
    end
    check_eq("work_ready", 64'(bus.work_ready), 64'd1);
    if (expect_hits) begin
      for (longint unsigned i = 0; i <= longint'(span); i++) begin
        n = ns + 32'(i);
        if ((match_all || n == golden) && (keep < 0 || pushed < keep)) begin
          sb.push_back(n);
          pushed++;
        end
      end
    end
    bus.work_header = h;
    bus.work_target = t;
    bus.work_nstart = ns;
    bus.work_nend   = ne;
    bus.work_valid  = 1'b1;
    tick(1);
    bus.work_valid  = 1'b0;
    check_eq("first_nonce", 64'(core_nonce), 64'(ns));
    check_eq("busy_sweep", 64'(busy), 64'd1);
    check_eq("done_cleared", 64'(done), 64'd0);
    check_eq("core_header", 64'(core_header == h), 64'd1);
    check_eq("core_target", 64'(core_target), 64'(t));
  endtask

  task automatic wait_done(input int exp_cycles, input int elapsed);
    int c;
    c = elapsed;
    while (!done && c < 3000) begin
      tick(1);
      c++;
    end
    check_eq("done", 64'(done), 64'd1);
    check_eq("done_latency", 64'(c), 64'(exp_cycles));
  endtask

  task automatic drain_fifo();
    int c;
    c = 0;
    bus.gn_ready = 1'b1;
    while (bus.gn_valid && c < 20) begin
      tick(1);
      c++;
    end
    check_eq("fifo_drained", 64'(bus.gn_valid), 64'd0);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  localparam logic [HDR_W-1:0] HDR = {32'h0100_0000, {18{32'h3BA3_EDFD}}};

  initial begin
    rst_n = 1'b0;
    abort = 1'b0;
    bus.work_valid  = 1'b0;
    bus.work_header = '0;
    bus.work_target = '0;
    bus.work_nstart = '0;
    bus.work_nend   = '0;
    bus.gn_ready    = 1'b1;
    tick(2);
    rst_n = 1'b1;
    check_eq("rst_work_ready", 64'(bus.work_ready), 64'd1);
    check_eq("rst_gn_valid", 64'(bus.gn_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_core_nonce", 64'(core_nonce), 64'd0);
    check_eq("rst_core_header", 64'(core_header == '0), 64'd1);

    // 1: single golden nonce in a 17-nonce range
    golden = 32'h3682_BB08;
    start_job(HDR, 32'h0000_0009, 32'h3682_BB00, 32'h3682_BB10, 1'b1, -1);
    wait_done(17 + L, 0);
    tick(2);
    check_eq("t1_sb_empty", 64'(sb.size()), 64'd0);

    // 2: wrap across 0xFFFFFFFF
    golden = 32'h0000_0000;
    start_job(~HDR, 32'h1234_5678, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, -1);
    tick(1); check_eq("wrap_n1", 64'(core_nonce), 64'hFFFF_FFFF);
    tick(1); check_eq("wrap_n2", 64'(core_nonce), 64'h0);
    tick(1); check_eq("wrap_n3", 64'(core_nonce), 64'h1);
    tick(1); check_eq("wrap_hold", 64'(core_nonce), 64'h1);
    check_eq("wrap_drain_busy", 64'(busy), 64'd1);
    wait_done(4 + L, 4);
    tick(2);
    check_eq("t2_sb_empty", 64'(sb.size()), 64'd0);

    // 3: overflow with consumer stalled
    bus.gn_ready = 1'b0;
    match_all = 1'b1;
    start_job(HDR, 32'h9, 32'd100, 32'd105, 1'b1, 4);
    wait_done(6 + L, 0);
    match_all = 1'b0;
    check_eq("ovf_set", 64'(overflow), 64'd1);
    check_eq("ovf_gn_valid", 64'(bus.gn_valid), 64'd1);
    drain_fifo();
    check_eq("ovf_sticky", 64'(overflow), 64'd1);

    // 4: abort after golden issued; prior FIFO entry preserved
    bus.gn_ready = 1'b0;
    golden = 32'd11;
    start_job(HDR, 32'h9, 32'd10, 32'd12, 1'b1, -1);
    check_eq("ovf_cleared", 64'(overflow), 64'd0);
    wait_done(3 + L, 0);
    golden = 32'd1020;
    start_job(HDR, 32'h9, 32'd1000, 32'd1100, 1'b0, -1);
    tick(20);
    check_eq("abort_at_golden", 64'(core_nonce), 64'd1020);
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_idle", 64'(bus.work_ready), 64'd1);
    check_eq("abort_done", 64'(done), 64'd0);
    tick(L + 5);
    check_eq("abort_prior_kept", 64'(bus.gn_valid), 64'd1);
    drain_fifo();

    // 5: reset mid-sweep
    bus.gn_ready = 1'b0;
    golden = 32'd21;
    start_job(HDR, 32'h9, 32'd20, 32'd22, 1'b1, -1);
    wait_done(3 + L, 0);
    check_eq("pre_rst_gn_valid", 64'(bus.gn_valid), 64'd1);
    golden = 32'd5010;
    start_job(HDR, 32'h9, 32'd5000, 32'd5100, 1'b0, -1);
    tick(12);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    sb.delete();
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_ready", 64'(bus.work_ready), 64'd1);
    check_eq("mid_rst_gn_valid", 64'(bus.gn_valid), 64'd0);
    check_eq("mid_rst_nonce", 64'(core_nonce), 64'd0);
    check_eq("mid_rst_target", 64'(core_target), 64'd0);
`ifdef KECCAK_HASH_CNT_EN
    check_eq("mid_rst_hash_cnt", 64'(hash_cnt), 64'd0);
`endif
    bus.gn_ready = 1'b1;
    tick(L + 5);
    check_eq("stale_match_ignored", 64'(bus.gn_valid), 64'd0);

    // 6: 100-nonce job then single-nonce job (nend == nstart)
    golden = 32'hDEAD_BEEF;
    start_job(HDR, 32'h9, 32'd0, 32'd99, 1'b1, -1);
    wait_done(100 + L, 0);
`ifdef KECCAK_HASH_CNT_EN
    check_eq("hash_cnt_100", 64'(hash_cnt), 64'd100);
`endif
    golden = 32'd7;
    start_job(HDR, 32'h9, 32'd7, 32'd7, 1'b1, -1);
    wait_done(1 + L, 0);
`ifdef KECCAK_HASH_CNT_EN
    check_eq("hash_cnt_101", 64'(hash_cnt), 64'd101);
`endif
    tick(3);
    check_eq("final_sb_empty", 64'(sb.size()), 64'd0);
    check_eq("final_gn_valid", 64'(bus.gn_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
